// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache uses the slave modport; the datapath/memory side uses master.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits are answered combinationally; a miss fetches one word from memory,
// fills the line and returns to IDLE where the request hits.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | answer fetches from the array, detect misses
//   ST_FETCH | iREN held high on the latched miss address until iwait=0
module icache #(
  parameter int SETS = 16
) (
  input logic    CLK,
  input logic    nRST,
  icache_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  logic [0:0]    r_state;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0] r_tag  [SETS];
  logic [31:0]   r_data [SETS];
  logic [29:0]   r_miss_addr;      // word address; byte offset is always 0
  logic [31:0]   r_hit_count;
  logic [31:0]   r_miss_count;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_fill_idx;
  logic [TW-1:0] w_fill_tag;
  logic          w_idle;
  logic          w_hit;
  logic          w_miss;
  logic          w_fill;
  logic          w_unused_ok;

  assign w_idx       = bus.imemaddr[IW+1:2];
  assign w_tag       = bus.imemaddr[31:IW+2];
  assign w_fill_idx  = r_miss_addr[IW-1:0];
  assign w_fill_tag  = r_miss_addr[29:IW];
  // byte offset within the word plays no part in lookup
  assign w_unused_ok = &{1'b0, bus.imemaddr[1:0]};

  assign w_idle = (r_state == ST_IDLE);
  assign w_hit  = w_idle & bus.imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = w_idle & bus.imemREN & ~w_hit;
  assign w_fill = ~w_idle & ~bus.iwait;

  assign bus.ihit       = w_hit;
  assign bus.imemload   = w_idle ? r_data[w_idx] : 32'd0;
  assign bus.iREN       = ~w_idle;
  assign bus.iaddr      = w_idle ? 32'd0 : {r_miss_addr, 2'b00};
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  // FSM, miss address latch and event counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_IDLE;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit)
        r_hit_count <= r_hit_count + 32'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_miss_addr  <= bus.imemaddr[31:2];
            r_miss_count <= r_miss_count + 32'd1;
            r_state      <= ST_FETCH;
          end
        end
        default: begin
          if (w_fill)
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // line storage; a fill overwrites whatever the line held before
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
      r_tag[w_fill_idx]   <= w_fill_tag;
      r_data[w_fill_idx]  <= bus.iload;
    end
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the datapath's instruction-fetch requests on `datapath_cache_if` (imemREN/imemaddr to ihit/imemload). On a miss it fetches one word from the memory controller over the cache-side `iREN/iaddr/iwait/iload` handshake, fills the line, then hits. It sits between the pipelined datapath's IF stage and the memory controller.

## Interface
Parameters:
- `SETS`, 16: number of one-word lines; must be a power of two ≥ 2. IW = $clog2(SETS), TW = 30 − IW.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `imemREN`  in  1  datapath fetch request
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored
- `ihit`  out  1  imemload valid this cycle; the datapath advances its PC on it
- `imemload`  out  32  instruction word
- `iREN`  out  1  memory read request
- `iaddr`  out  32  memory word address, bits [1:0] = 0
- `iwait`  in  1  memory busy; low = iload valid this cycle
- `iload`  in  32  memory read data
- `hit_count`  out  32  number of cycles with ihit = 1
- `miss_count`  out  32  number of IDLE→FETCH transitions

## Operation
- Address split: tag = imemaddr[31:IW+2], index = imemaddr[IW+1:2].
- Per line: valid bit, TW-bit tag, 32-bit data. No writes from the datapath, no coherence, no flush port.
- FSM has two states: IDLE and FETCH.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index] == addr tag).
  - ihit = hit, combinationally. imemload = data[index] whenever state is IDLE, regardless of hit.
  - On imemREN & ~hit: latch {imemaddr[31:2], 2'b00} into miss_addr, increment miss_count, go to FETCH.
  - With imemREN = 0: ihit = 0 and the cache stays in IDLE.
- FETCH:
  - iREN = 1, iaddr = miss_addr, ihit = 0, imemload = 0.
  - When iwait = 0: write data = iload, tag = miss_addr tag and valid = 1 at the miss_addr index, then return to IDLE.
  - While iwait = 1: hold FETCH, iREN and iaddr.
  - imemREN and imemaddr are ignored in FETCH. A fill always completes to the latched address, even if the request drops or the address changes.
- A fill overwrites the line unconditionally. An old valid line with a different tag is simply replaced.
- hit_count increments on every cycle with ihit = 1.
- Both counters wrap modulo 2^32.
- Reset, asynchronous and immediate, including mid-FETCH:
  - state = IDLE, all valid = 0, tags and data = 0, miss_addr = 0, counters = 0.
  - Outputs: iREN = 0, iaddr = 0, ihit = 0, imemload = 0.
  - An interrupted fill is discarded; no line is written.

## Timing
- Hit: zero latency. ihit and imemload are combinational from imemaddr in the same cycle.
- Miss detected in cycle 0 (ihit = 0). FETCH begins in cycle 1 with iREN = 1.
- If iwait first goes low in cycle k ≥ 1, the line is written at the end of cycle k.
- Cycle k+1 is back in IDLE with ihit = 1, if the request is unchanged.
- Minimum miss penalty: 2 cycles, with iwait = 0 in cycle 1, so ihit arrives in cycle 2.
- iREN is registered-state-derived: glitch-free and stable for the whole of FETCH.
- In IDLE, iREN is 0 in every cycle, including the miss-detect cycle.
- Back-to-back misses: the IDLE cycle after a fill re-evaluates hit. A different missing address enters FETCH again one cycle later.
- Aliasing: two addresses with the same index and different tags evict each other. Alternating between them misses on every access.

## Test plan
- Reset then cold fetch:
  - Stimulus: imemREN = 1, imemaddr = 0x0000_0004, memory returns 0x2001_0005 with iwait low on the 3rd FETCH cycle.
  - Required: iREN = 1 and iaddr = 0x4 for 3 cycles, then ihit = 1 with imemload = 0x2001_0005; miss_count = 1.
- Re-fetch 0x4 after the fill:
  - Required: ihit = 1 in the same cycle, iREN stays 0, hit_count increments by 1 per ihit cycle.
- Conflict with SETS = 16:
  - Stimulus: fetch 0x0000_0000 (fill 0xAAAA_AAAA), then 0x0000_0040 (fill 0xBBBB_BBBB), then 0x0000_0000 again.
  - Required: third access misses, refetches and returns 0xAAAA_AAAA; miss_count = 3.
- Request change mid-FETCH:
  - Stimulus: miss on 0x10, then change imemaddr to 0x20 while iwait = 1.
  - Required: iaddr stays 0x10 and the fill lands in index 4. Next IDLE cycle: 0x20 misses and iaddr = 0x20.
- Reset mid-FETCH:
  - Stimulus: assert nRST = 0 while iREN = 1.
  - Required: iREN, ihit, imemload and both counters drop to 0 immediately. After release, the same address misses again because no line was written.
- Low address bits ignored:
  - Stimulus: fetch 0x0000_0007 after filling 0x0000_0004.
  - Required: hit, with imemload equal to the 0x4 word.
